alu_seq: RTL
============

# alu_seq

Parametrised WIDTH-bit registered ALU with a valid/ready handshake on input and output, flag outputs, and an optional multi-cycle shift-add multiplier. It is the next generation of the team's ripple-carry 4-bit ALU, generalised in width and extended with a real pipeline register, backpressure and a sequential multiply. It sits between the operand/decode stage (upstream) and the writeback stage (downstream).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clock  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept; transfer on `in_valid && in_ready` at a rising edge.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation code (see Operation).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts; transfer on `out_valid && out_ready`.
- result  output  WIDTH  registered result.
- cout  output  1  adder carry out (ADD/SUB only, else 0).
- zero  output  1  `result == 0`.
- ovf  output  1  signed overflow (ADD/SUB); for MUL, high half of product nonzero.
- err  output  1  illegal op was issued.

## Operation
- Op codes:
  - 000 AND.
  - 001 OR.
  - 010 ADD: A+B.
  - 110 SUB: A+~B+1.
  - 111 SLT: result = {0…,lt}, where lt = sign(A−B) XOR ovf(A−B), i.e. a signed compare.
  - 100 NOR.
  - 011 MUL: unsigned, low WIDTH bits of the product.
  - 101 reserved.
- Reserved op, or 011 when the multiplier is compiled out: result=0, zero=1, err=1, cout=0, ovf=0.
- SUB: cout=1 means no borrow. SLT, logic ops: cout=0, ovf=0.
- FSM states:
  - IDLE: accept; single-cycle ops load the output register directly and stay IDLE; MUL goes to BUSY.
  - BUSY: one partial product per cycle, WIDTH iterations, using an LSB-first shift of B and a 2·WIDTH-bit accumulator; after the last iteration, write output register, return to IDLE.
- Output register holds result and flags stable while `out_valid && !out_ready`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready) && !reset`. A new op may be accepted on the same edge the previous result is consumed.
- Operands are captured at acceptance; later input changes have no effect on an op in flight.

## Timing
- Reset values: out_valid=0, result=0, cout=0, zero=0, ovf=0, err=0, state=IDLE, iteration counter=0.
- in_ready is 0 while reset is high and 1 on the first cycle after reset deasserts.
- Single-cycle ops:
  - Accepted at edge k, out_valid=1 after edge k (latency 1).
  - MUL accepted at edge k, out_valid=1 after edge k+WIDTH (latency WIDTH).
  - in_ready=0 from after edge k until the result is presented.
- out_valid falls after the consuming edge unless a new single-cycle op is accepted on that same edge. In that case out_valid stays 1 with the new result (back-to-back throughput 1/cycle).
- Reset asserted mid-MUL aborts the op: no result is produced, and the registers take reset values on that edge.
- Counter width is ceil(log2(WIDTH+1)); the counter never wraps within one op.

## Configuration
- ALU_SEQ_MUL_EN defined: BUSY state, counter, accumulator and op 011 are compiled in as described.
- Not defined: no BUSY state or accumulator; op 011 behaves as reserved (err=1, latency 1). in_ready then reduces to `!out_valid || out_ready`.

## Test plan
All scenarios use WIDTH=8.
- ADD A=8'h7F, B=8'h01 → one cycle later: result=8'h80, ovf=1, cout=0, zero=0, err=0.
- SUB A=8'h05, B=8'h05 → result=8'h00, zero=1, cout=1, ovf=0. SLT A=8'hFF, B=8'h01 → result=8'h01.
- MUL A=8'h10, B=8'h10 (macro on) → in_ready=0 for 8 cycles; out_valid after edge k+8 with result=8'h00, zero=1, ovf=1. MUL 8'h0D×8'h0B → result=8'h8F, ovf=0.
- Backpressure: ADD result presented, out_ready=0 for 3 cycles → result/flags stable, in_ready=0. Raise out_ready with a new OR op valid → both transfers occur on the same edge, and out_valid stays 1 with the OR result.
- Reset at 3rd cycle of MUL → out_valid never asserts for that op, all outputs 0, in_ready=1 the cycle after reset drops.
- Op 101 → result=0, zero=1, err=1 at latency 1. With macro off, op 011 → identical response.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake and flags.
// Define ALU_SEQ_MUL_EN to compile in the sequential shift-add multiplier (op 011).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_r, ld_r, res_q, res_d;
  logic             add_v, sub_v, alu_c, alu_v, alu_e;
  logic             fire, ld, ld_c, ld_v, ld_e;
  logic             vld_q, vld_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

  always_comb begin
    add_s = {1'b0, in_a} + {1'b0, in_b};
    sub_s = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
    add_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_s[WIDTH-1] != in_a[WIDTH-1]);
    sub_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_s[WIDTH-1] != in_a[WIDTH-1]);
    alu_r = in_op == 3'b000 ? in_a & in_b :
            in_op == 3'b001 ? in_a | in_b :
            in_op == 3'b100 ? ~(in_a | in_b) :
            in_op == 3'b010 ? add_s[WIDTH-1:0] :
            in_op == 3'b110 ? sub_s[WIDTH-1:0] :
            in_op == 3'b111 ? {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_v} : '0;
    alu_c = in_op == 3'b010 ? add_s[WIDTH] : in_op == 3'b110 ? sub_s[WIDTH] : 1'b0;
    alu_v = in_op == 3'b010 ? add_v : in_op == 3'b110 ? sub_v : 1'b0;
    // 011 only reaches this path as an error when the multiplier is absent
    alu_e = in_op == 3'b101 || in_op == 3'b011;
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mc_q, mc_d, acc_nx;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_mul, done;

  assign in_ready = state_q == IDLE && (!vld_q || out_ready) && !reset;
  assign fire     = in_valid && in_ready;

  always_comb begin
    is_mul  = in_op == 3'b011;
    acc_nx  = acc_q + (mp_q[0] ? mc_q : '0);
    done    = state_q == BUSY && cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    if (state_q == BUSY) begin
      acc_d   = acc_nx;
      mc_d    = mc_q << 1;
      mp_d    = mp_q >> 1;
      cnt_d   = done ? '0 : cnt_q + CW'(1);
      state_d = done ? IDLE : BUSY;
    end else if (fire && is_mul) begin
      acc_d   = '0;
      mc_d    = {{WIDTH{1'b0}}, in_a};
      mp_d    = in_b;
      cnt_d   = '0;
      state_d = BUSY;
    end
    ld   = (fire && !is_mul) || done;
    ld_r = done ? acc_nx[WIDTH-1:0] : alu_r;
    ld_c = done ? 1'b0 : alu_c;
    ld_v = done ? |acc_nx[2*WIDTH-1:WIDTH] : alu_v;
    ld_e = done ? 1'b0 : alu_e;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign in_ready = (!vld_q || out_ready) && !reset;
  assign fire     = in_valid && in_ready;

  always_comb begin
    ld   = fire;
    ld_r = alu_r;
    ld_c = alu_c;
    ld_v = alu_v;
    ld_e = alu_e;
  end
`endif

  always_comb begin
    vld_d  = ld || (vld_q && !out_ready);
    res_d  = ld ? ld_r : res_q;
    cout_d = ld ? ld_c : cout_q;
    zero_d = ld ? ld_r == '0 : zero_q;
    ovf_d  = ld ? ld_v : ovf_q;
    err_d  = ld ? ld_e : err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
endmodule
